// File: rtl/sched_32b_8b_pkg.sv
// Shared types and constants for the 32-bit to 8-bit round-robin serializer.
package sched_32b_8b_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int          BYTES_PER_WORD = 4;
  localparam logic [1:0]  LAST_PHASE     = 2'(BYTES_PER_WORD - 1);
  localparam logic [7:0]  IDLE_BYTE      = 8'hBC;
  localparam logic [7:0]  IDLE_ZERO      = 8'h00;

  // Phase 0 is the most significant byte.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] ph);
    case (ph)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

endpackage

// File: rtl/sched_32b_8b_if.sv
// Requester-side word handshake plus the serialized byte stream of sched_32b_8b.
interface sched_32b_8b_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [32*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic [7:0]          data_out;
  logic                valid_out;
  logic [ID_W-1:0]     src_id;
  logic                busy;

  modport master (
    output req_valid, req_data,
    input  req_ready, data_out, valid_out, src_id, busy
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, data_out, valid_out, src_id, busy
  );
endinterface

// File: rtl/sched_32b_8b_rr_arbiter.sv
// Combinational round-robin arbiter: searches from last_grant+1, wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  input  logic             enable,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any_grant
);

  // First pass covers indices above last_grant, second pass wraps to 0..last_grant.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    if (enable) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!any_grant && req[i] && (i > int'(last_grant))) begin
          grant[i]  = 1'b1;
          grant_idx = ID_W'(i);
          any_grant = 1'b1;
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (!any_grant && req[i] && (i <= int'(last_grant))) begin
          grant[i]  = 1'b1;
          grant_idx = ID_W'(i);
          any_grant = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sched_32b_8b.sv
// Round-robin scheduler feeding one 32->8 serializer, MSB byte first, tagged with source index.
// Optional macro ARB_IDLE_BC_EN: idle byte is 8'hBC (K28.5) instead of 8'h00.
module sched_32b_8b
  import sched_32b_8b_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk_4f,
  input  logic                 reset,
  sched_32b_8b_if.slave        bus
);

`ifdef ARB_IDLE_BC_EN
  localparam logic [7:0] IDLE_OUT = IDLE_BYTE;
`else
  localparam logic [7:0] IDLE_OUT = IDLE_ZERO;
`endif

  state_t            state;
  logic [1:0]        phase;
  logic [31:0]       word_p0;
  logic [ID_W-1:0]   last_grant;
  logic [7:0]        byte_p1;
  logic              vld_p1;
  logic [ID_W-1:0]   id_p1;

  logic              slot_open;
  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_idx;
  logic              accept;
  logic [31:0]       sel_word;

  // An accept slot exists when idle or while the last byte of a word is on the output.
  assign slot_open = ~reset & ((state == IDLE) | (phase == LAST_PHASE));

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .enable     (slot_open),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any_grant  (accept)
  );

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) sel_word = bus.req_data[32*i +: 32];
    end
  end

  // Stage p0: held word and phase; stage p1: registered byte, valid and tag.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      phase      <= 2'd0;
      word_p0    <= '0;
      last_grant <= ID_W'(N_REQ - 1);
      byte_p1    <= IDLE_OUT;
      vld_p1     <= 1'b0;
      id_p1      <= '0;
    end else if (accept) begin
      state      <= SEND;
      phase      <= 2'd0;
      word_p0    <= sel_word;
      last_grant <= grant_idx;
      byte_p1    <= word_byte(sel_word, 2'd0);
      vld_p1     <= 1'b1;
      id_p1      <= grant_idx;
    end else if (state == SEND) begin
      if (phase == LAST_PHASE) begin
        state   <= IDLE;
        phase   <= 2'd0;
        byte_p1 <= IDLE_OUT;
        vld_p1  <= 1'b0;
      end else begin
        phase   <= phase + 2'd1;
        byte_p1 <= word_byte(word_p0, phase + 2'd1);
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.data_out  = byte_p1;
  assign bus.valid_out = vld_p1;
  assign bus.src_id    = id_p1;
  assign bus.busy      = (state == SEND);

endmodule

// File: tb/tb_sched_32b_8b.sv
// Bench for sched_32b_8b: directed scenarios plus random traffic against a byte-queue reference model.
module tb_sched_32b_8b;
  import sched_32b_8b_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;
`ifdef ARB_IDLE_BC_EN
  localparam logic [7:0] EXP_IDLE = 8'hBC;
`else
  localparam logic [7:0] EXP_IDLE = 8'h00;
`endif

  logic clk_4f = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_4f = ~clk_4f;

  sched_32b_8b_if #(.N_REQ(N), .ID_W(IW)) bus ();

  sched_32b_8b #(.N_REQ(N), .ID_W(IW)) dut (
    .clk_4f (clk_4f),
    .reset  (reset),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Per-requester words waiting to be accepted; head is what the requester presents.
  logic [31:0] pend [N][$];
  // Reference model: bytes still to appear on data_out (head = currently shown).
  logic [7:0]  mq_b [$];
  int          mq_id [$];
  int          m_last;
  int          m_src;
  // Observed payload bytes, and expected ones for directed scenarios.
  logic [7:0]  log_b [$];
  int          log_id [$];
  logic [7:0]  exp_b [$];
  int          exp_id [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq_b.delete();
    mq_id.delete();
    m_last = N - 1;
    m_src  = 0;
  endtask

  function automatic int model_pick();
    int c;
    if (reset || mq_b.size() > 1) return -1;
    for (int k = 1; k <= N; k++) begin
      c = (m_last + k) % N;
      if (pend[c].size() > 0) return c;
    end
    return -1;
  endfunction

  task automatic model_edge(input int w);
    logic [31:0] word;
    if (w >= 0) begin
      word = pend[w][0];
      mq_b.delete();
      mq_id.delete();
      for (int b = 3; b >= 0; b--) begin
        mq_b.push_back(word[8*b +: 8]);
        mq_id.push_back(w);
      end
      m_last = w;
      void'(pend[w].pop_front());
    end else if (mq_b.size() > 0) begin
      void'(mq_b.pop_front());
      void'(mq_id.pop_front());
    end
    if (mq_b.size() > 0) m_src = mq_id[0];
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]        = (pend[i].size() > 0);
      bus.req_data[32*i +: 32] = (pend[i].size() > 0) ? pend[i][0] : (32'hDEAD_0000 | 32'(i));
    end
  endtask

  task automatic check_outputs(input string pfx);
    logic exp_v;
    exp_v = (mq_b.size() > 0);
    chk({pfx, "valid_out"}, 32'(bus.valid_out), 32'(exp_v));
    chk({pfx, "data_out"},  32'(bus.data_out),  exp_v ? 32'(mq_b[0]) : 32'(EXP_IDLE));
    chk({pfx, "src_id"},    32'(bus.src_id),    32'(m_src));
    chk({pfx, "busy"},      32'(bus.busy),      32'(exp_v));
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "req_ready"}, 32'(bus.req_ready), 32'd0);
    check_outputs(pfx);
  endtask

  task automatic cycle();
    int w;
    apply();
    #1;
    w = model_pick();
    chk("req_ready", 32'(bus.req_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
    @(posedge clk_4f);
    model_edge(w);
    #1;
    check_outputs("");
    if (bus.valid_out === 1'b1) begin
      log_b.push_back(bus.data_out);
      log_id.push_back(int'(bus.src_id));
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic exp_word(input int id, input logic [31:0] w);
    for (int b = 3; b >= 0; b--) begin
      exp_b.push_back(w[8*b +: 8]);
      exp_id.push_back(id);
    end
  endtask

  task automatic chk_log(input string tag);
    int n;
    chk({tag, "_len"}, 32'(log_b.size()), 32'(exp_b.size()));
    n = (log_b.size() < exp_b.size()) ? log_b.size() : exp_b.size();
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_byte%0d", tag, k), 32'(log_b[k]), 32'(exp_b[k]));
      chk($sformatf("%s_id%0d", tag, k),   32'(log_id[k]), 32'(exp_id[k]));
    end
    log_b.delete();
    log_id.delete();
    exp_b.delete();
    exp_id.delete();
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    model_reset();
    repeat (2) @(posedge clk_4f);
    #1;
    check_reset("rst_");
    @(negedge clk_4f);
    reset = 1'b0;

    // Contention from a fresh reset: 0,1,2,3
    for (int i = 0; i < N; i++) pend[i].push_back(32'hA0A0A0A0 + 32'(i));
    run(18);
    for (int i = 0; i < N; i++) exp_word(i, 32'hA0A0A0A0 + 32'(i));
    chk_log("contention");

    // Fairness wrap after grant 3
    pend[3].push_back(32'h3333_3333);
    pend[1].push_back(32'h1111_1111);
    run(10);
    exp_word(1, 32'h1111_1111);
    exp_word(3, 32'h3333_3333);
    chk_log("fair");

    // Requester 2 withdraws during phase 1 of requester 0's word
    pend[0].push_back(32'h1234_5678);
    pend[2].push_back(32'h2222_2222);
    pend[1].push_back(32'h0000_0003);
    run(2);
    pend[2].delete();
    run(8);
    exp_word(0, 32'h1234_5678);
    exp_word(1, 32'h0000_0003);
    chk_log("drop");

    // Single word
    pend[0].push_back(32'hFFFBBFFF);
    run(7);
    exp_word(0, 32'hFFFBBFFF);
    chk_log("single");

    // Back-to-back on requester 0
    pend[0].push_back(32'hFFFBBFFF);
    pend[0].push_back(32'hDDDDDDDD);
    run(10);
    exp_word(0, 32'hFFFBBFFF);
    exp_word(0, 32'hDDDDDDDD);
    chk_log("b2b");

    // Asynchronous reset during phase 2
    pend[2].push_back(32'hAAAAAAAA);
    run(3);
    chk("mid_byte_before_rst", 32'(bus.data_out), 32'hAA);
    pend[1].push_back(32'h1111_0000);
    apply();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_reset("rst_mid_");
    @(posedge clk_4f);
    #1;
    check_reset("rst_hold_");
    pend[0].push_back(32'h0F0F_0F0F);
    reset = 1'b0;
    log_b.delete();
    log_id.delete();
    run(10);
    exp_word(0, 32'h0F0F_0F0F);
    exp_word(1, 32'h1111_0000);
    chk_log("post_rst");

    // Random traffic, including occasional withdrawals
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (pend[i].size() < 2 && $urandom_range(0, 3) == 0) pend[i].push_back($urandom);
      end
      if ($urandom_range(0, 31) == 0) pend[$urandom_range(0, N - 1)].delete();
      cycle();
    end
    for (int i = 0; i < N; i++) pend[i].delete();
    run(6);
    chk("final_idle_valid", 32'(bus.valid_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
